// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding data-memory responder with programmable latency
// Word-organised RAM with byte-lane writes; response is registered out of the RESP state.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic        we_re,
  input  logic [3:0]  mask,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        valid,
  output logic [31:0] load_data,
  output logic        err
);

  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept;
  logic        resp;

  logic        cap_we;
  logic [3:0]  cap_mask;
  logic [31:2] cap_addr;
  logic [31:0] cap_data;

  logic [31:0] mem [0:DEPTH_WORDS-1];

  logic              in_range;
  logic [ADDR_W-1:0] word_idx;
  logic              do_write;

  // Byte offset is the core's concern; the responder works on whole words.
  logic unused_byte_offset;
  assign unused_byte_offset = &{1'b0, address[1:0]};

  assign in_range = (cap_addr[31:ADDR_W+2] == '0);
  assign word_idx = cap_addr[ADDR_W+1:2];
  assign do_write = resp & cap_we & in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    resp      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (request) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = (LATENCY > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_RESP: begin
        resp      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_we   <= 1'b0;
      cap_mask <= 4'd0;
      cap_addr <= '0;
      cap_data <= 32'd0;
    end else if (accept) begin
      cap_we   <= we_re;
      cap_mask <= mask;
      cap_addr <= address[31:2];
      cap_data <= store_data;
    end
  end

  // Array is never cleared; a reset on the committing edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_mask[i]) begin
          mem[word_idx][8*i +: 8] <= cap_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= 1'b0;
      err       <= 1'b0;
      load_data <= 32'd0;
    end else begin
      valid     <= resp;
      err       <= resp & ~in_range;
      load_data <= (resp && !cap_we && in_range) ? mem[word_idx] : 32'd0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed and randomized checks of data_mem_responder
// Three instances: LATENCY 1, 0 and 3, compared against an associative-array memory model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req [3];
  logic        we  [3];
  logic [3:0]  msk [3];
  logic [31:0] adr [3];
  logic [31:0] sd  [3];
  logic        vld [3];
  logic [31:0] ld  [3];
  logic        er  [3];

  int lat_of [3] = '{1, 0, 3};
  logic [31:0] ref_mem [int];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .ADDR_W(10), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .request(req[0]), .we_re(we[0]), .mask(msk[0]),
    .address(adr[0]), .store_data(sd[0]), .valid(vld[0]), .load_data(ld[0]), .err(er[0]));
  data_mem_responder #(.DEPTH_WORDS(1024), .ADDR_W(10), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .request(req[1]), .we_re(we[1]), .mask(msk[1]),
    .address(adr[1]), .store_data(sd[1]), .valid(vld[1]), .load_data(ld[1]), .err(er[1]));
  data_mem_responder #(.DEPTH_WORDS(1024), .ADDR_W(10), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .request(req[2]), .we_re(we[2]), .mask(msk[2]),
    .address(adr[2]), .store_data(sd[2]), .valid(vld[2]), .load_data(ld[2]), .err(er[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic int key(input int d, input logic [31:0] a);
    return d * 65536 + int'(a / 4);
  endfunction

  // One full transaction; expectations come from the word-array model and the latency rule.
  task automatic access(input int d, input logic w, input logic [3:0] m,
                        input logic [31:0] a, input logic [31:0] data, input string tag);
    logic [31:0] exp_ld;
    logic [31:0] word;
    logic        exp_err;
    logic        got;
    logic        idle_bad;
    int          n;
    exp_ld  = 32'd0;
    exp_err = !((a / 4) < 1024);
    if (!exp_err) begin
      if (w) begin
        word = ref_mem.exists(key(d, a)) ? ref_mem[key(d, a)] : 32'd0;
        for (int i = 0; i < 4; i++)
          if (m[i]) word[8*i +: 8] = data[8*i +: 8];
        ref_mem[key(d, a)] = word;
      end else begin
        exp_ld = ref_mem[key(d, a)];
      end
    end
    @(posedge clk); #1;
    req[d] = 1'b1; we[d] = w; msk[d] = m; adr[d] = a; sd[d] = data;
    got = 1'b0; idle_bad = 1'b0; n = 0;
    for (int k = 1; k <= 24 && !got; k++) begin
      @(posedge clk); #1;
      if (k == 1) req[d] = 1'b0;
      if (vld[d]) begin
        got = 1'b1;
        n = k;
      end else if (ld[d] !== 32'd0 || er[d] !== 1'b0) begin
        idle_bad = 1'b1;
      end
    end
    chk({tag, "_latency"}, n, lat_of[d] + 2);
    chk({tag, "_load_data"}, ld[d], exp_ld);
    chk({tag, "_err"}, {31'd0, er[d]}, {31'd0, exp_err});
    chk({tag, "_quiet_before"}, {31'd0, idle_bad}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_single_pulse"}, {31'd0, vld[d]}, 32'd0);
  endtask

  initial begin
    logic [31:0] pool [8];
    logic [31:0] old8;
    logic [31:0] a;
    int          pulses;
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; msk[d] = 4'd0; adr[d] = 32'd0; sd[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_valid", {31'd0, vld[d]}, 32'd0);
      chk("reset_load_data", ld[d], 32'd0);
      chk("reset_err", {31'd0, er[d]}, 32'd0);
    end
    rst = 1'b0;

    access(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, "wr_10");
    access(0, 1'b0, 4'h0, 32'h10, 32'h0, "rd_10");
    access(0, 1'b1, 4'hF, 32'h20, 32'h11223344, "wr_20");
    access(0, 1'b1, 4'b0010, 32'h20, 32'h0000AA00, "wr_20_lane1");
    access(0, 1'b0, 4'hF, 32'h20, 32'h0, "rd_20");
    access(0, 1'b1, 4'hF, 32'h0, 32'h13579BDF, "wr_0");
    access(0, 1'b0, 4'hF, 32'h1000, 32'h0, "rd_oor");
    access(0, 1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, "wr_oor");
    access(0, 1'b0, 4'hF, 32'h0, 32'h0, "rd_0");
    access(0, 1'b1, 4'hF, 32'h30, 32'h55AA55AA, "wr_30");
    access(0, 1'b1, 4'h0, 32'h30, 32'hFFFFFFFF, "wr_30_nomask");
    access(0, 1'b0, 4'hF, 32'h30, 32'h0, "rd_30");
    access(0, 1'b0, 4'hF, 32'h13, 32'h0, "rd_10_misaligned");

    access(1, 1'b1, 4'hF, 32'h4, 32'hA5A5_0F0F, "l0_wr_4");
    access(1, 1'b0, 4'hF, 32'h4, 32'h0, "l0_rd_4");
    // Request held for six sampling edges: one acceptance per LATENCY+2 cycles.
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h4;
    pulses = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (k == 6) req[1] = 1'b0;
      if (vld[1]) pulses++;
    end
    chk("l0_hold_pulses", pulses, (6 + lat_of[1] + 1) / (lat_of[1] + 2));

    old8 = $urandom;
    access(2, 1'b1, 4'hF, 32'h8, old8, "l3_wr_8");
    @(posedge clk); #1;
    req[2] = 1'b1; we[2] = 1'b1; msk[2] = 4'hF; adr[2] = 32'h8; sd[2] = 32'hCAFEF00D;
    @(posedge clk); #1;
    req[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_mid_valid", {31'd0, vld[d]}, 32'd0);
      chk("rst_mid_load_data", ld[d], 32'd0);
      chk("rst_mid_err", {31'd0, er[d]}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (vld[2]) pulses++;
    end
    chk("rst_mid_no_valid", pulses, 0);
    access(2, 1'b0, 4'hF, 32'h8, 32'h0, "l3_rd_8_after_abort");

    for (int i = 0; i < 8; i++) begin
      pool[i] = $urandom_range(0, 1023) * 4;
      access(0, 1'b1, 4'hF, pool[i], $urandom, "rnd_init");
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0)
        a = ($urandom & 32'hFFFF_FFFC) | 32'h0000_1000;
      else
        a = pool[$urandom_range(0, 7)];
      a = a | 32'($urandom_range(0, 3));
      access(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, "rnd_op");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
